// File: rtl/io_dcc_pkg.sv
// Shared definitions for the IO duty-cycle-correction calibration block:
// state and direction encodings, code width/range and the gray helper.
package io_dcc_pkg;

  localparam int unsigned CODE_W   = 4;
  localparam int unsigned CODE_MAX = 15;

  // Controller states
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_SAMPLE = 3'd2;
  localparam logic [2:0] ST_UPDATE = 3'd3;
  localparam logic [2:0] ST_LOCKED = 3'd4;

  // Correction direction of one decision
  localparam logic [1:0] DIR_UP   = 2'd0;
  localparam logic [1:0] DIR_DOWN = 2'd1;
  localparam logic [1:0] DIR_HOLD = 2'd2;
  localparam logic [1:0] DIR_NONE = 2'd3;

  // Binary to reflected gray for the delay-line code bus
  function automatic logic [3:0] bin2gray4(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/io_dcc_code_step.sv
// One-step code adjust for the rise/fall delay pair. UP lengthens the high
// phase (remove fall delay first, then add rise delay is the opposite path),
// DOWN shortens it; at most one of the two codes is ever nonzero.
module io_dcc_code_step
  import io_dcc_pkg::*;
(
  input  logic [CODE_W-1:0] r_code,
  input  logic [CODE_W-1:0] f_code,
  input  logic [1:0]        dir,
  output logic [CODE_W-1:0] r_next_c,
  output logic [CODE_W-1:0] f_next_c,
  output logic              sat_c
);

  // Step the active code toward the requested direction, flag range exhaustion
  always_comb begin
    r_next_c = r_code;
    f_next_c = f_code;
    sat_c    = 1'b0;
    case (dir)
      DIR_UP: begin
        if (r_code != '0)
          r_next_c = r_code - CODE_W'(1);
        else if (f_code != CODE_W'(CODE_MAX))
          f_next_c = f_code + CODE_W'(1);
        else
          sat_c = 1'b1;
      end
      DIR_DOWN: begin
        if (f_code != '0)
          f_next_c = f_code - CODE_W'(1);
        else if (r_code != CODE_W'(CODE_MAX))
          r_next_c = r_code + CODE_W'(1);
        else
          sat_c = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/io_dcc_cal_ctrl.sv
// Closed-loop duty-cycle-correction calibration controller. Majority-votes
// the duty-cycle detector over a window, steps the rise/fall delay codes one
// LSB per decision and declares lock after repeated direction reversals.
// Optional macro DCC_CAL_OVRD_EN adds a direct code override port group.
module io_dcc_cal_ctrl
  import io_dcc_pkg::*;
#(
  parameter int unsigned SETTLE_CYC   = 16,
  parameter int unsigned SAMPLE_CNT   = 8,
  parameter int unsigned LOCK_TOGGLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cal_en,
  input  logic              dcd_hi,
`ifdef DCC_CAL_OVRD_EN
  input  logic              ovrd_en,
  input  logic [CODE_W-1:0] ovrd_r_code,
  input  logic [CODE_W-1:0] ovrd_f_code,
`endif
  output logic [CODE_W-1:0] r_gray,
  output logic [CODE_W-1:0] f_gray,
  output logic              cal_busy,
  output logic              cal_done,
  output logic              cal_sat
);

  localparam int unsigned CNT_MAX = (SETTLE_CYC > SAMPLE_CNT) ? SETTLE_CYC : SAMPLE_CNT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned HI_W    = $clog2(SAMPLE_CNT + 1);
  localparam int unsigned TOG_W   = 4;

  logic [2:0]        state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [HI_W-1:0]   hi_cnt, hi_d;
  logic [CODE_W-1:0] r_code, r_d;
  logic [CODE_W-1:0] f_code, f_d;
  logic [CODE_W-1:0] step_r, step_f;
  logic              step_sat;
  logic              sat_d;
  logic [TOG_W-1:0]  toggle_cnt, tog_d;
  logic [1:0]        prev_dir, prev_d;
  logic [1:0]        dir;
  logic              reversal;
  logic              busy_d;
  logic              done_d;

  // Majority decision over the finished window and reversal detection
  always_comb begin
    dir = DIR_HOLD;
    if (hi_cnt > HI_W'(SAMPLE_CNT / 2))
      dir = DIR_DOWN;
    else if (hi_cnt < HI_W'(SAMPLE_CNT / 2))
      dir = DIR_UP;
    reversal = (dir == DIR_HOLD) || ((prev_dir != DIR_NONE) && (dir != prev_dir));
  end

  io_dcc_code_step u_step (
    .r_code   (r_code),
    .f_code   (f_code),
    .dir      (dir),
    .r_next_c (step_r),
    .f_next_c (step_f),
    .sat_c    (step_sat)
  );

  // Next-state and next-value logic for the calibration loop
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    hi_d    = hi_cnt;
    r_d     = r_code;
    f_d     = f_code;
    sat_d   = cal_sat;
    tog_d   = toggle_cnt;
    prev_d  = prev_dir;

    case (state)
      ST_IDLE: begin
        if (cal_en) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
          hi_d    = '0;
          r_d     = '0;
          f_d     = '0;
          sat_d   = 1'b0;
          tog_d   = '0;
          prev_d  = DIR_NONE;
        end
      end
      ST_SETTLE: begin
        if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
          cnt_d   = '0;
          hi_d    = '0;
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      ST_SAMPLE: begin
        hi_d = hi_cnt + HI_W'(dcd_hi);
        if (cnt == CNT_W'(SAMPLE_CNT - 1)) begin
          cnt_d   = '0;
          state_d = ST_UPDATE;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      ST_UPDATE: begin
        r_d   = step_r;
        f_d   = step_f;
        cnt_d = '0;
        if (step_sat)
          sat_d = 1'b1;
        tog_d = reversal ? (toggle_cnt + TOG_W'(1)) : '0;
        if (dir != DIR_HOLD)
          prev_d = dir;
        state_d = (tog_d == TOG_W'(LOCK_TOGGLES)) ? ST_LOCKED : ST_SETTLE;
      end
      ST_LOCKED: begin
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Dropping enable abandons the loop but keeps codes and the sticky flag
    if (!cal_en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      hi_d    = '0;
      r_d     = r_code;
      f_d     = f_code;
      sat_d   = cal_sat;
      tog_d   = toggle_cnt;
      prev_d  = prev_dir;
    end

`ifdef DCC_CAL_OVRD_EN
    // Override takes the codes directly and parks the controller
    if (ovrd_en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      hi_d    = '0;
      r_d     = ovrd_r_code;
      f_d     = ovrd_f_code;
    end
`endif

    // Busy is raised one cycle after leaving IDLE and dropped on lock/abort
    busy_d = (state != ST_IDLE) &&
             ((state_d == ST_SETTLE) || (state_d == ST_SAMPLE) || (state_d == ST_UPDATE));
    done_d = (state_d == ST_LOCKED);
  end

  // State, counters, codes and registered gray outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      hi_cnt     <= '0;
      r_code     <= '0;
      f_code     <= '0;
      toggle_cnt <= '0;
      prev_dir   <= DIR_NONE;
      cal_sat    <= 1'b0;
      cal_busy   <= 1'b0;
      cal_done   <= 1'b0;
      r_gray     <= '0;
      f_gray     <= '0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      hi_cnt     <= hi_d;
      r_code     <= r_d;
      f_code     <= f_d;
      toggle_cnt <= tog_d;
      prev_dir   <= prev_d;
      cal_sat    <= sat_d;
      cal_busy   <= busy_d;
      cal_done   <= done_d;
      r_gray     <= bin2gray4(r_code);
      f_gray     <= bin2gray4(f_code);
    end
  end

endmodule
